// File: rtl/patternbuf_shadow_pkg.sv
// rtl/patternbuf_shadow_pkg.sv - shared sizing helper for the pattern buffer
package patternbuf_shadow_pkg;

    function automatic int frame_bits(input int width, input int size);
        return width * size;
    endfunction

endpackage

// File: rtl/patternbuf_shadow_if.sv
// rtl/patternbuf_shadow_if.sv - serial load, commit and field read signals of the pattern buffer
interface patternbuf_shadow_if
    import patternbuf_shadow_pkg::*;
#(
    parameter int BUF_WIDTH = 8,
    parameter int BUF_SIZE  = 32,
    parameter int PTR_W     = $clog2(BUF_SIZE),
    parameter int CNT_W     = $clog2(frame_bits(BUF_WIDTH, BUF_SIZE) + 1)
);
    logic                 ssel;
    logic                 sin;
    logic                 sout;
    logic                 commit;
    logic [PTR_W-1:0]     fieldp;
    logic [BUF_WIDTH-1:0] field_byte;
    logic                 frame_full;
    logic                 active_valid;
    logic                 overflow;
    logic                 commit_err;
    logic [CNT_W-1:0]     bit_count;

    modport master (
        output ssel, sin, commit, fieldp,
        input  sout, field_byte, frame_full, active_valid, overflow, commit_err, bit_count
    );

    modport slave (
        input  ssel, sin, commit, fieldp,
        output sout, field_byte, frame_full, active_valid, overflow, commit_err, bit_count
    );

endinterface

// File: rtl/patternbuf_rdmux.sv
// rtl/patternbuf_rdmux.sv - combinational one-hot read mux over the flattened active bank
module patternbuf_rdmux #(
    parameter int BUF_WIDTH = 8,
    parameter int BUF_SIZE  = 32,
    parameter int PTR_W     = $clog2(BUF_SIZE)
) (
    input  logic [BUF_WIDTH*BUF_SIZE-1:0] data,
    input  logic [PTR_W-1:0]              sel,
    output logic [BUF_WIDTH-1:0]          q
);

    // No entry matches an out-of-range pointer, so the OR reduction yields zero.
    always_comb begin
        q = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            q = q | ({BUF_WIDTH{sel == PTR_W'(i)}} & data[i*BUF_WIDTH +: BUF_WIDTH]);
        end
    end

endmodule

// File: rtl/patternbuf_shadow.sv
// rtl/patternbuf_shadow.sv - shadow shift chain with validated commit into a registered-read active bank
module patternbuf_shadow
    import patternbuf_shadow_pkg::*;
#(
    parameter int BUF_WIDTH = 8,
    parameter int BUF_SIZE  = 32,
    parameter int PTR_W     = $clog2(BUF_SIZE),
    parameter int CNT_W     = $clog2(frame_bits(BUF_WIDTH, BUF_SIZE) + 1)
) (
    input  logic               sclk,
    input  logic               rstn,
    patternbuf_shadow_if.slave bus
);

    localparam int               FRAME     = frame_bits(BUF_WIDTH, BUF_SIZE);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);

    logic [BUF_WIDTH-1:0] shadow [BUF_SIZE];
    logic [BUF_WIDTH-1:0] active [BUF_SIZE];
    logic [FRAME-1:0]     active_flat;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 full;
    logic                 do_commit;
    logic [BUF_WIDTH-1:0] rd_data;
    logic [BUF_WIDTH-1:0] field_q;
    logic                 valid_q;
    logic                 ovf_q;
    logic                 cerr_q;

    assign full      = (cnt == FRAME_CNT);
    assign do_commit = bus.commit & full;

    // A commit restarts the frame; a shift on the same edge is its first bit.
    always_comb begin
        cnt_next = cnt;
        if (do_commit) begin
            cnt_next = bus.ssel ? CNT_W'(1) : '0;
        end else if (bus.ssel && !full) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                shadow[i] <= '0;
            end
        end else if (bus.ssel) begin
            shadow[0] <= {shadow[0][BUF_WIDTH-2:0], bus.sin};
            for (int i = 1; i < BUF_SIZE; i++) begin
                shadow[i] <= {shadow[i][BUF_WIDTH-2:0], shadow[i-1][BUF_WIDTH-1]};
            end
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                active[i] <= '0;
            end
        end else if (do_commit) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            valid_q <= valid_q | do_commit;
            ovf_q   <= ovf_q | (bus.ssel & full);
            cerr_q  <= cerr_q | (bus.commit & ~full);
        end
    end

    always_comb begin
        active_flat = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            active_flat[i*BUF_WIDTH +: BUF_WIDTH] = active[i];
        end
    end

    patternbuf_rdmux #(
        .BUF_WIDTH (BUF_WIDTH),
        .BUF_SIZE  (BUF_SIZE),
        .PTR_W     (PTR_W)
    ) u_rdmux (
        .data (active_flat),
        .sel  (bus.fieldp),
        .q    (rd_data)
    );

    // Reads the pre-commit bank when a commit lands on the same edge.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            field_q <= '0;
        end else begin
            field_q <= rd_data;
        end
    end

    assign bus.sout         = shadow[BUF_SIZE-1][BUF_WIDTH-1];
    assign bus.field_byte   = field_q;
    assign bus.frame_full   = full;
    assign bus.active_valid = valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.commit_err   = cerr_q;
    assign bus.bit_count    = cnt;

endmodule

// File: tb/tb_patternbuf_shadow.sv
// tb/tb_patternbuf_shadow.sv - directed self-checking bench for patternbuf_shadow
module tb_patternbuf_shadow;

    logic sclk;
    logic rstn_a;
    logic rstn_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] fa1;
    logic [255:0] fa2;
    logic [255:0] fa2x;
    logic [255:0] fa3;
    logic [79:0]  fb;

    patternbuf_shadow_if #(.BUF_WIDTH(8), .BUF_SIZE(32)) bus_a ();
    patternbuf_shadow_if #(.BUF_WIDTH(4), .BUF_SIZE(20)) bus_b ();

    patternbuf_shadow #(.BUF_WIDTH(8), .BUF_SIZE(32)) dut_a (
        .sclk (sclk),
        .rstn (rstn_a),
        .bus  (bus_a)
    );

    patternbuf_shadow #(.BUF_WIDTH(4), .BUF_SIZE(20)) dut_b (
        .sclk (sclk),
        .rstn (rstn_b),
        .bus  (bus_b)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic shift_a(input logic b);
        bus_a.ssel = 1'b1;
        bus_a.sin  = b;
        tick();
        bus_a.ssel = 1'b0;
        bus_a.sin  = 1'b0;
    endtask

    task automatic shift_b(input logic b);
        bus_b.ssel = 1'b1;
        bus_b.sin  = b;
        tick();
        bus_b.ssel = 1'b0;
        bus_b.sin  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            fa1[k*8 +: 8] = 8'(k);
            fa2[k*8 +: 8] = 8'(k) ^ 8'hA5;
            fa3[k*8 +: 8] = 8'(k * 37 + 11);
        end
        for (int k = 0; k < 20; k++) begin
            fb[k*4 +: 4] = 4'(k + 3);
        end
        fa2x = {fa2[252:0], 3'b101};

        rstn_a = 1'b0;
        rstn_b = 1'b0;
        bus_a.ssel = 1'b1; bus_a.sin = 1'b0; bus_a.commit = 1'b0; bus_a.fieldp = '0;
        bus_b.ssel = 1'b1; bus_b.sin = 1'b0; bus_b.commit = 1'b0; bus_b.fieldp = '0;

        // Reset held with shifting requested
        for (int i = 0; i < 6; i++) begin
            bus_a.sin = i[0];
            bus_b.sin = ~i[0];
            tick();
        end
        check("rst_a_bit_count", 64'(bus_a.bit_count), 0);
        check("rst_a_sout", 64'(bus_a.sout), 0);
        check("rst_a_frame_full", 64'(bus_a.frame_full), 0);
        check("rst_a_active_valid", 64'(bus_a.active_valid), 0);
        check("rst_a_overflow", 64'(bus_a.overflow), 0);
        check("rst_a_commit_err", 64'(bus_a.commit_err), 0);
        check("rst_a_field_byte", 64'(bus_a.field_byte), 0);
        check("rst_b_bit_count", 64'(bus_b.bit_count), 0);
        check("rst_b_sout", 64'(bus_b.sout), 0);

        bus_a.ssel = 1'b0;
        bus_b.ssel = 1'b0;
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        tick();
        check("post_rst_a_bit_count", 64'(bus_a.bit_count), 0);

        // Full frame load, entry k = k, MSB of entry 31 first
        for (int j = 255; j >= 0; j--) begin
            shift_a(fa1[j]);
            if (j == 255) check("a_first_shift_count", 64'(bus_a.bit_count), 1);
            if (j == 1)   check("a_255_not_full", 64'(bus_a.frame_full), 0);
        end
        check("a_256_full", 64'(bus_a.frame_full), 1);
        check("a_256_count", 64'(bus_a.bit_count), 256);
        check("a_256_sout", 64'(bus_a.sout), 64'(fa1[255]));

        bus_a.commit = 1'b1;
        bus_a.fieldp = 5'd5;
        tick();
        bus_a.commit = 1'b0;
        check("a_commit_valid", 64'(bus_a.active_valid), 1);
        check("a_commit_count", 64'(bus_a.bit_count), 0);
        check("a_commit_no_err", 64'(bus_a.commit_err), 0);
        check("a_commit_same_edge_old", 64'(bus_a.field_byte), 0);
        tick();
        check("a_field5", 64'(bus_a.field_byte), 64'h05);

        // Early commit after 100 bits
        for (int j = 255; j >= 156; j--) shift_a(fa2[j]);
        bus_a.commit = 1'b1;
        tick();
        bus_a.commit = 1'b0;
        check("early_commit_err", 64'(bus_a.commit_err), 1);
        check("early_commit_count", 64'(bus_a.bit_count), 100);
        tick();
        check("early_commit_active_kept", 64'(bus_a.field_byte), 64'h05);

        for (int j = 155; j >= 0; j--) shift_a(fa2[j]);
        check("a2_full_count", 64'(bus_a.bit_count), 256);
        check("a2_sout", 64'(bus_a.sout), 64'(fa2[255]));

        // Overflow: three extra shifts on a full frame
        shift_a(1'b1);
        check("ovf_flag", 64'(bus_a.overflow), 1);
        check("ovf_count", 64'(bus_a.bit_count), 256);
        check("ovf_sout1", 64'(bus_a.sout), 64'(fa2[254]));
        shift_a(1'b0);
        check("ovf_sout2", 64'(bus_a.sout), 64'(fa2[253]));
        shift_a(1'b1);
        check("ovf_sout3", 64'(bus_a.sout), 64'(fa2[252]));
        check("ovf_still_full", 64'(bus_a.frame_full), 1);

        bus_a.commit = 1'b1;
        bus_a.fieldp = 5'd0;
        tick();
        bus_a.commit = 1'b0;
        check("ovf_commit_count", 64'(bus_a.bit_count), 0);
        tick();
        check("ovf_commit_entry0", 64'(bus_a.field_byte), 64'(fa2x[7:0]));
        bus_a.fieldp = 5'd31;
        tick();
        check("ovf_commit_entry31", 64'(bus_a.field_byte), 64'(fa2x[255:248]));
        check("ovf_sticky", 64'(bus_a.overflow), 1);

        // Commit and shift on the same edge of a full frame
        for (int j = 255; j >= 0; j--) shift_a(fa3[j]);
        bus_a.commit = 1'b1;
        bus_a.ssel   = 1'b1;
        bus_a.sin    = 1'b1;
        tick();
        bus_a.commit = 1'b0;
        bus_a.ssel   = 1'b0;
        bus_a.sin    = 1'b0;
        check("simul_count", 64'(bus_a.bit_count), 1);
        check("simul_not_full", 64'(bus_a.frame_full), 0);
        for (int k = 0; k < 32; k++) begin
            bus_a.fieldp = 5'(k);
            tick();
            check($sformatf("sweep_%0d", k), 64'(bus_a.field_byte), 64'(fa3[k*8 +: 8]));
        end

        // Non-power-of-two depth: W=4, SIZE=20
        for (int j = 79; j >= 0; j--) begin
            shift_b(fb[j]);
            if (j == 1) begin
                check("b_79_not_full", 64'(bus_b.frame_full), 0);
                check("b_79_count", 64'(bus_b.bit_count), 79);
            end
        end
        check("b_80_full", 64'(bus_b.frame_full), 1);
        check("b_80_count", 64'(bus_b.bit_count), 80);

        bus_b.commit = 1'b1;
        bus_b.fieldp = 5'd25;
        tick();
        bus_b.commit = 1'b0;
        check("b_commit_valid", 64'(bus_b.active_valid), 1);
        tick();
        check("b_field25_zero", 64'(bus_b.field_byte), 0);
        bus_b.fieldp = 5'd19;
        tick();
        check("b_field19", 64'(bus_b.field_byte), 64'(fb[79:76]));
        bus_b.fieldp = 5'd0;
        tick();
        check("b_field0", 64'(bus_b.field_byte), 64'h3);

        // Asynchronous reset in the middle of a load
        for (int j = 79; j >= 40; j--) shift_b(fb[j]);
        check("b_mid_count", 64'(bus_b.bit_count), 40);
        @(posedge sclk);
        #3;
        rstn_b = 1'b0;
        #1;
        check("b_async_count", 64'(bus_b.bit_count), 0);
        check("b_async_valid", 64'(bus_b.active_valid), 0);
        check("b_async_field", 64'(bus_b.field_byte), 0);
        check("b_async_full", 64'(bus_b.frame_full), 0);
        check("b_async_sout", 64'(bus_b.sout), 0);
        tick();
        rstn_b = 1'b1;
        bus_b.fieldp = 5'd19;
        tick();
        check("b_after_rst_count", 64'(bus_b.bit_count), 0);
        check("b_after_rst_field19", 64'(bus_b.field_byte), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
